// File: rtl/sniffer_fifo_pkg.sv
// Shared helpers for the sniffer stream FIFO.
// - ptr_width / level_width: address and occupancy widths for a given depth
// - ptr_inc: pointer increment that wraps at DEPTH-1 for any depth
package sniffer_fifo_pkg;

   // Address width needed to index DEPTH words (DEPTH >= 2).
   function automatic int unsigned ptr_width(input int unsigned depth);
      return $clog2(depth);
   endfunction

   // Width of a count that must reach DEPTH itself.
   function automatic int unsigned level_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // Explicit wrap so non-power-of-two depths work.
   function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/sniffer_fifo_ram.sv
// Simple dual-port storage for the sniffer FIFO.
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write word
//   raddr - read address (asynchronous read)
//   rdata - word at raddr
module sniffer_fifo_ram #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned AW         = 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sniffer_stream_fifo.sv
// Synchronous FIFO between the I2C sniffer front end and the UART transmitter.
// Any depth, registered or first-word-fall-through read, threshold flags,
// exact occupancy count, sticky error flags and synchronous flush.
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   flush            - synchronous clear of pointers/level (errors kept)
//   clr_err          - clears overflow/underflow (a same-cycle set wins)
//   wr_en, wr_data   - write request and word
//   rd_en            - pop request
//   rd_data,rd_valid - read word and its qualifier
//   full, empty, almost_full, almost_empty - flags decoded from level
//   level            - occupancy 0..DEPTH
//   overflow, underflow - sticky error flags
module sniffer_stream_fifo
   import sniffer_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned DEPTH         = 256,
   parameter int unsigned AFULL_THRESH  = DEPTH - 4,
   parameter int unsigned AEMPTY_THRESH = 4,
   parameter bit          FWFT          = 1'b0
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              flush,
   input  logic                              clr_err,
   input  logic                              wr_en,
   input  logic [DATA_WIDTH-1:0]             wr_data,
   input  logic                              rd_en,
   output logic [DATA_WIDTH-1:0]             rd_data,
   output logic                              rd_valid,
   output logic                              full,
   output logic                              empty,
   output logic                              almost_full,
   output logic                              almost_empty,
   output logic [level_width(DEPTH)-1:0]     level,
   output logic                              overflow,
   output logic                              underflow
);

   localparam int unsigned PW = ptr_width(DEPTH);
   localparam int unsigned LW = level_width(DEPTH);

   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]         level_q, level_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic                  wr_acc, rd_acc, ram_we;

   // Flags come from the registered count only, so no input reaches an output.
   assign full         = (level_q == LW'(DEPTH));
   assign empty        = (level_q == '0);
   assign almost_full  = (32'(level_q) >= AFULL_THRESH);
   assign almost_empty = (32'(level_q) <= AEMPTY_THRESH);

   assign wr_acc = wr_en && !full;
   assign rd_acc = rd_en && !empty;
   assign ram_we = wr_acc && !flush;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      rd_data_d   = rd_data_q;
      rd_valid_d  = 1'b0;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      if (clr_err) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end

      if (flush) begin
         // Concurrent requests are dropped entirely, including error detection.
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (wr_en && full) overflow_d = 1'b1;
         if (rd_en && empty) underflow_d = 1'b1;
         if (wr_acc) wr_ptr_d = PW'(ptr_inc(32'(wr_ptr_q), DEPTH));
         if (rd_acc) begin
            rd_ptr_d   = PW'(ptr_inc(32'(rd_ptr_q), DEPTH));
            rd_data_d  = ram_rdata;
            rd_valid_d = 1'b1;
         end
         unique case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   sniffer_fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (PW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wr_ptr_q),
      .wdata (wr_data),
      .raddr (rd_ptr_q),
      .rdata (ram_rdata)
   );

   // FWFT shows the head word directly; zero when empty keeps reset/idle value clean.
   assign rd_data   = FWFT ? (empty ? '0 : ram_rdata) : rd_data_q;
   assign rd_valid  = FWFT ? !empty : rd_valid_q;
   assign level     = level_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule
